sseg_disp_arbiter: RTL and testbench

//  Shares the 4-digit seven-segment display between NREQ requesters.

---
 rtl/sseg_disp_arbiter_pkg.sv | 35 +++
 rtl/sseg_disp_arbiter_if.sv | 28 ++
 rtl/sseg_disp_arbiter_rr_pick.sv | 31 +++
 rtl/sseg_disp_arbiter.sv | 122 ++++++++++++
 tb/tb_sseg_disp_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_disp_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter and its clients.
package sseg_disp_arbiter_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned HEX_W           = 16;
  localparam int unsigned DP_W            = 4;
  localparam int unsigned DEF_NREQ        = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 50_000_000;
  localparam int unsigned DEF_CNT_W       = 26;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] hex3;
    logic [DIGIT_W-1:0] hex2;
    logic [DIGIT_W-1:0] hex1;
    logic [DIGIT_W-1:0] hex0;
    logic [DP_W-1:0]    dp;
  } disp_t;

  // Split a requester's packed digit word (hex3 in the MSBs) into display fields.
  function automatic disp_t make_disp(input logic [HEX_W-1:0] hex, input logic [DP_W-1:0] dp);
    disp_t d;
    d.hex3 = hex[15:12];
    d.hex2 = hex[11:8];
    d.hex1 = hex[7:4];
    d.hex0 = hex[3:0];
    d.dp   = dp;
    return d;
  endfunction

endpackage

// File: rtl/sseg_disp_arbiter_if.sv
// Requester bundle and display outputs of the seven-segment display arbiter.
interface sseg_disp_arbiter_if
  import sseg_disp_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
);
  logic [NREQ-1:0]       req;
  logic [HEX_W*NREQ-1:0] req_hex;
  logic [DP_W*NREQ-1:0]  req_dp;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [DIGIT_W-1:0]    hex3;
  logic [DIGIT_W-1:0]    hex2;
  logic [DIGIT_W-1:0]    hex1;
  logic [DIGIT_W-1:0]    hex0;
  logic [DP_W-1:0]       dp_out;

  modport master (
    output req, req_hex, req_dp,
    input  ack, grant, busy, hex3, hex2, hex1, hex0, dp_out
  );

  modport slave (
    input  req, req_hex, req_dp,
    output ack, grant, busy, hex3, hex2, hex1, hex0, dp_out
  );
endinterface

// File: rtl/sseg_disp_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module sseg_disp_arbiter_rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          any_c,
  output logic [IW-1:0] idx_c,
  output logic [N-1:0]  onehot_c
);

  int unsigned cand;

  // Offset 1 first, so the previous winner is searched last.
  always_comb begin
    any_c = 1'b0;
    idx_c = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_i) + k) % N;
      if (!any_c && req_i[IW'(cand)]) begin
        any_c = 1'b1;
        idx_c = IW'(cand);
      end
    end
  end

  assign onehot_c = any_c ? (N'(1) << idx_c) : '0;

endmodule

// File: rtl/sseg_disp_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum hold time per grant.
module sseg_disp_arbiter
  import sseg_disp_arbiter_pkg::*;
#(
  parameter int unsigned NREQ        = DEF_NREQ,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input logic                clk,
  input logic                reset,
  sseg_disp_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_last_q, rr_last_d;
  disp_t              disp_q, disp_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               busy_q, busy_d;

  logic               pick_any_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [NREQ-1:0]    pick_onehot_c;
  logic               arb_c;
  logic               relatch_c;
  logic [IDX_W-1:0]   lat_idx_c;
  logic [HEX_W-1:0]   hex_sel_c;
  logic [DP_W-1:0]    dp_sel_c;

  sseg_disp_arbiter_rr_pick #(.N(NREQ)) u_pick (
    .req_i    (bus.req),
    .last_i   (rr_last_q),
    .any_c    (pick_any_c),
    .idx_c    (pick_idx_c),
    .onehot_c (pick_onehot_c)
  );

  assign lat_idx_c = arb_c ? pick_idx_c : owner_q;
  assign hex_sel_c = HEX_W'(bus.req_hex >> (HEX_W * 32'(lat_idx_c)));
  assign dp_sel_c  = DP_W'(bus.req_dp >> (DP_W * 32'(lat_idx_c)));

  // Arbitration happens from IDLE or at hold expiry; mid-hold only the owner may update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    disp_d    = disp_q;
    ack_d     = '0;
    grant_d   = grant_q;
    busy_d    = busy_q;
    arb_c     = 1'b0;
    relatch_c = 1'b0;

    case (state_q)
      ST_IDLE: arb_c = pick_any_c;
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CNT_W'(1);
          relatch_c = bus.req[owner_q];
        end else if (pick_any_c) begin
          arb_c = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb_c) begin
      state_d   = ST_HOLD;
      cnt_d     = CNT_W'(HOLD_CYCLES - 1);
      owner_d   = pick_idx_c;
      rr_last_d = pick_idx_c;
      grant_d   = pick_onehot_c;
      busy_d    = 1'b1;
      ack_d     = pick_onehot_c;
      disp_d    = make_disp(hex_sel_c, dp_sel_c);
    end else if (relatch_c) begin
      ack_d  = grant_q;
      disp_d = make_disp(hex_sel_c, dp_sel_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      rr_last_q <= IDX_W'(NREQ - 1);
      disp_q    <= '0;
      ack_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      disp_q    <= disp_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.grant  = grant_q;
  assign bus.busy   = busy_q;
  assign bus.hex3   = disp_q.hex3;
  assign bus.hex2   = disp_q.hex2;
  assign bus.hex1   = disp_q.hex1;
  assign bus.hex0   = disp_q.hex0;
  assign bus.dp_out = disp_q.dp;

endmodule

// File: tb/tb_sseg_disp_arbiter.sv
// Bench for sseg_disp_arbiter: directed scenarios plus random traffic against a timestamp-based model.
module tb_sseg_disp_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sseg_disp_arbiter_if #(.NREQ(NREQ)) bus ();

  sseg_disp_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [NREQ-1:0] r_req;
  logic [15:0]     r_hex [NREQ];
  logic [3:0]      r_dp  [NREQ];

  // Model: owner (-1 = none), edge index of its grant, last winner, displayed data, ack target.
  int          m_owner, m_start, m_rr, m_ack, cyc;
  logic [15:0] m_hex;
  logic [3:0]  m_dp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot(input int i);
    return (i < 0) ? 32'd0 : (32'd1 << i);
  endfunction

  task automatic apply();
    bus.req = r_req;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_hex[16*i +: 16] = r_hex[i];
      bus.req_dp[4*i +: 4]    = r_dp[i];
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_start = 0; m_rr = NREQ - 1; m_ack = -1; cyc = 0;
    m_hex = 16'h0; m_dp = 4'h0;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      int c = (m_rr + k) % NREQ;
      if (r_req[c]) return c;
    end
    return -1;
  endfunction

  function automatic void latch(input int w);
    m_hex = r_hex[w];
    m_dp  = r_dp[w];
    m_ack = w;
  endfunction

  // One clock edge of the model using the inputs presented before the edge.
  function automatic void model_step();
    cyc++;
    m_ack = -1;
    if (m_owner < 0 || (cyc - m_start) >= HOLD) begin
      int w = pick();
      if (w >= 0) begin
        latch(w);
        m_owner = w; m_rr = w; m_start = cyc;
      end else begin
        m_owner = -1;
      end
    end else if (r_req[m_owner]) begin
      latch(m_owner);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack",   32'(bus.ack),   onehot(m_ack));
      chk("grant", 32'(bus.grant), onehot(m_owner));
      chk("busy",  32'(bus.busy),  32'(m_owner >= 0));
      chk("hex",   32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'(m_hex));
      chk("dp",    32'(bus.dp_out), 32'(m_dp));
    end
  end

  task automatic check_reset_vals();
    chk("rst_ack",   32'(bus.ack),   32'h0);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_hex",   32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'h0);
    chk("rst_dp",    32'(bus.dp_out), 32'h0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals();
    model_reset();
    r_req = '0;
    apply();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    r_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_hex[i] = 16'(16'h1111 * (i + 1));
      r_dp[i]  = 4'(i + 8);
    end
    apply();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals();
    chk_en = 1'b1;

    // Single requester: one-cycle latency to ack and display.
    r_hex[0] = 16'h1234; r_dp[0] = 4'b0101; r_req = 4'b0001; apply();
    step();
    chk("t1_ack", 32'(bus.ack), 32'h1);
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    chk("t1_digits", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'h1234);
    chk("t1_dp", 32'(bus.dp_out), 32'h5);
    r_req = '0; apply();
    repeat (HOLD) step();
    chk("t1_idle_busy", 32'(bus.busy), 32'h0);
    chk("t1_keep_disp", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'h1234);

    // All requesting: rotation 0,1,2,3,0, exactly HOLD cycles per owner.
    do_reset();
    r_req = 4'b1111; apply();
    for (int g = 0; g < 5; g++) begin
      step();
      chk("t2_grant", 32'(bus.grant), 32'd1 << (g % 4));
      repeat (HOLD - 1) step();
      chk("t2_still", 32'(bus.grant), 32'd1 << (g % 4));
    end
    r_req = '0; apply();
    repeat (2) step();

    // Owner update mid-hold does not restart the hold; pending requester 1 wins at expiry.
    do_reset();
    r_hex[2] = 16'h5555; r_req = 4'b0100; apply();
    step();
    chk("t3_grant2", 32'(bus.grant), 32'h4);
    r_req = 4'b0010; apply();
    repeat (2) step();
    r_hex[2] = 16'hABCD; r_req = 4'b0110; apply();
    step();
    chk("t3_upd_ack", 32'(bus.ack), 32'h4);
    chk("t3_upd_disp", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'hABCD);
    r_req = 4'b0010; apply();
    repeat (4) step();
    chk("t3_hold", 32'(bus.grant), 32'h4);
    step();
    chk("t3_expiry", 32'(bus.grant), 32'h2);
    chk("t3_exp_ack", 32'(bus.ack), 32'h2);
    r_req = '0; apply();
    repeat (HOLD) step();
    chk("t3_idle", 32'(bus.busy), 32'h0);

    // Sole requester is re-granted at expiry; then release lets busy drop with display kept.
    r_hex[0] = 16'h0F1E; r_req = 4'b0001; apply();
    step();
    repeat (HOLD) step();
    chk("t4_regrant", 32'(bus.grant), 32'h1);
    chk("t4_reack", 32'(bus.ack), 32'h1);
    r_req = '0; apply();
    repeat (HOLD - 1) step();
    chk("t4_busy_hi", 32'(bus.busy), 32'h1);
    step();
    chk("t4_busy_lo", 32'(bus.busy), 32'h0);
    chk("t4_grant0", 32'(bus.grant), 32'h0);
    chk("t4_disp", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'h0F1E);

    // Reset mid-hold, then requester 0 has first priority again.
    r_req = 4'b1111; apply();
    step();
    repeat (3) step();
    do_reset();
    r_req = 4'b1111; apply();
    step();
    chk("t5_first", 32'(bus.grant), 32'h1);
    r_req = '0; apply();
    repeat (HOLD + 1) step();

    // A one-cycle non-owner pulse is withdrawn: never acked, never granted.
    r_req = 4'b0010; apply();
    step();
    chk("t6_grant1", 32'(bus.grant), 32'h2);
    r_req = '0; apply();
    repeat (2) step();
    r_req = 4'b1000; apply();
    step();
    chk("t6_no_ack", 32'(bus.ack), 32'h0);
    r_req = '0; apply();
    repeat (5) step();
    chk("t6_idle", 32'(bus.busy), 32'h0);
    chk("t6_nogrant", 32'(bus.grant), 32'h0);

    // Random traffic; data only changes while its request is low.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_req[i]) begin
          if ($urandom_range(0, 2) == 0) r_req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          r_hex[i] = 16'($urandom);
          r_dp[i]  = 4'($urandom);
          r_req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        apply();
        step();
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
